// File: rtl/rf_ctrl.sv
// -----------------------------------------------------------------------------
// rf_ctrl : sequencing controller for a synchronous-read register-file SRAM.
//
// Hardwires x0 to zero, discards writes to x0, and forwards a write to a read
// of the same address issued in the same cycle so the read returns the new
// value. The SRAM has a one-cycle read latency, no reset, and returns old data
// on a same-address read/write.
//
// Optional feature (macro RF_CLEAR_EN): after reset, every SRAM entry is
// written with zero before ready is raised. Without the macro, ready is high
// as soon as reset is released and SRAM contents are undefined until written.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rs_req, rs1_addr, rs2_addr    read request and addresses (this cycle)
//   rd_we, rd_addr, rd_data       write request
//   rs1_data, rs2_data, rs_valid  read results, one cycle after rs_req
//   ready                         controller accepts reads and writes
//   sram_*                        SRAM read/write port connections
// -----------------------------------------------------------------------------
module rf_ctrl #(
    parameter int XLEN  = 32,
    parameter int depth = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rs_req,
    input  logic [depth-1:0] rs1_addr,
    input  logic [depth-1:0] rs2_addr,
    input  logic             rd_we,
    input  logic [depth-1:0] rd_addr,
    input  logic [XLEN-1:0]  rd_data,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             rs_valid,
    output logic             ready,
    output logic [depth-1:0] sram_rs1_addr,
    output logic [depth-1:0] sram_rs2_addr,
    output logic             sram_we,
    output logic [depth-1:0] sram_waddr,
    output logic [XLEN-1:0]  sram_wdata,
    input  logic [XLEN-1:0]  sram_rs1_data,
    input  logic [XLEN-1:0]  sram_rs2_data
);

    localparam logic [depth-1:0] ZERO_ADDR = {depth{1'b0}};
    localparam logic [XLEN-1:0]  ZERO_DATA = {XLEN{1'b0}};

    logic run_s;       // controller is in RUN and honours requests
    logic wr_ok_s;     // accepted write to a non-x0 register

    logic            rs_valid_q;
    logic            zero1_q, zero2_q;
    logic            fwd1_q, fwd2_q;
    logic [XLEN-1:0] fwd_data_q;

`ifdef RF_CLEAR_EN
    localparam logic [depth-1:0] LAST_IDX = {depth{1'b1}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [depth-1:0] clr_idx_q, clr_idx_d;

    // State register and clear index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= ZERO_ADDR;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state logic: walk every entry once, then stay in RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + {{(depth-1){1'b0}}, 1'b1};
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = ZERO_ADDR;
            end
        endcase
    end

    assign run_s = (state_q == ST_RUN);
`else
    assign run_s = 1'b1;
`endif

    assign ready         = run_s;
    assign wr_ok_s       = rd_we && (rd_addr != ZERO_ADDR);
    assign sram_rs1_addr = rs1_addr;
    assign sram_rs2_addr = rs2_addr;

    // SRAM write port: clear sweep while clearing, otherwise the filtered write.
    always_comb begin
        sram_we    = run_s && wr_ok_s;
        sram_waddr = rd_addr;
        sram_wdata = rd_data;
`ifdef RF_CLEAR_EN
        if (!run_s) begin
            sram_we    = 1'b1;
            sram_waddr = clr_idx_q;
            sram_wdata = ZERO_DATA;
        end else begin
            sram_we    = wr_ok_s;
        end
`endif
    end

    // Read pipeline flags aligned with the SRAM's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_valid_q <= 1'b0;
            zero1_q    <= 1'b1;
            zero2_q    <= 1'b1;
            fwd1_q     <= 1'b0;
            fwd2_q     <= 1'b0;
            fwd_data_q <= ZERO_DATA;
        end else begin
            rs_valid_q <= rs_req && run_s;
            if (run_s) begin
                zero1_q <= (rs1_addr == ZERO_ADDR);
                zero2_q <= (rs2_addr == ZERO_ADDR);
                // SRAM returns old data on a colliding write, so the new
                // value is captured here and substituted on the next cycle.
                fwd1_q  <= wr_ok_s && (rd_addr == rs1_addr);
                fwd2_q  <= wr_ok_s && (rd_addr == rs2_addr);
                if (rd_we) begin
                    fwd_data_q <= rd_data;
                end
            end
        end
    end

    assign rs_valid = rs_valid_q;
    // x0 beats forwarding, forwarding beats SRAM data.
    assign rs1_data = zero1_q ? ZERO_DATA : (fwd1_q ? fwd_data_q : sram_rs1_data);
    assign rs2_data = zero2_q ? ZERO_DATA : (fwd2_q ? fwd_data_q : sram_rs2_data);

endmodule
